// File: rtl/key_pkg.sv
// Shared timing defaults and counter sizing for the push-button conditioning path.
package key_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz
  localparam int REPEAT_DELAY_DEF    = 25000000; // 0.5 s
  localparam int REPEAT_PERIOD_DEF   = 5000000;  // 0.1 s

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce counter, hold-to-repeat blips and press-pulse detect.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_i,
  input  logic repeat_en_i,
  output logic key_out_o,
  output logic press_pulse_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
  logic          key_out_q, key_out_d;
  logic          press_q, press_d;
  logic          pressed_d, new_press, hit, blip_d;

  always_comb begin
    db_d      = db_q;
    db_cnt_d  = '0;
    hold_d    = '0;
    rep_d     = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = ~db_q;
      else                     db_cnt_d = db_cnt_q + CW'(1);
    end
    pressed_d = ~db_d;
    new_press = db_q & ~db_d;
    // rep_q selects which interval the hold counter is timing: first delay or repeat period
    hit = (hold_q == (rep_q ? PERIOD_C : DELAY_C));
    if (pressed_d && repeat_en_i && !new_press) begin
      if (hit) begin
        hold_d = CW'(1);
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + CW'(1);
        rep_d  = rep_q;
      end
    end
    blip_d    = pressed_d && repeat_en_i && !new_press &&
                (hold_d == (rep_d ? PERIOD_C : DELAY_C));
    // A release always forces the line high, so it overrides any blip on the same cycle
    key_out_d = ~pressed_d | blip_d;
    press_d   = key_out_q & ~key_out_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      rep_q     <= 1'b0;
      key_out_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= key_raw_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
    end
  end

  assign key_out_o     = key_out_q;
  assign press_pulse_o = press_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NKEYS raw active-low push-buttons into clean levels with optional hold-to-repeat.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_raw,
  input  logic             repeat_en,
  output logic [NKEYS-1:0] key_out,
  output logic [NKEYS-1:0] press_pulse
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_raw_i    (key_raw[i]),
      .repeat_en_i  (repeat_en),
      .key_out_o    (key_out[i]),
      .press_pulse_o(press_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic       repeat_en;
  logic [3:0] key_out;
  logic [3:0] press_pulse;

  int n_cmp = 0;
  int n_err = 0;

  key_conditioner #(
    .NKEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .repeat_en  (repeat_en),
    .key_out    (key_out),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_raw = 4'hF;
    step();
    chk("reset_key_out", key_out, 4'hF);
    chk("reset_press", press_pulse, 4'h0);
    reset_n = 1'b1;
  endtask

  // Press key 0 from a clean released state; ends at hold cycle 0.
  task automatic press_key0(input string tag);
    key_raw[0] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk({tag, "_wait"}, key_out, 4'hF);
    end
    step();
    chk({tag, "_fall"}, key_out, 4'hE);
    chk({tag, "_press"}, press_pulse, 4'h1);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_raw   = 4'hF;
    repeat_en = 1'b1;
    repeat (3) step();
    chk("init_key_out", key_out, 4'hF);
    chk("init_press", press_pulse, 4'h0);
    reset_n = 1'b1;

    // 1: bounce on key 0, then settle low
    for (int seg = 0; seg < 4; seg++) begin
      key_raw[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        step();
        chk("bounce_key_out", key_out, 4'hF);
        chk("bounce_press", press_pulse, 4'h0);
      end
    end
    press_key0("t1");

    // 2: hold with repeat enabled, blips at 20,28,36,44
    for (int c = 1; c < 50; c++) begin
      logic blip, pulse;
      blip  = (c == 20) || (c == 28) || (c == 36) || (c == 44);
      pulse = (c == 21) || (c == 29) || (c == 37) || (c == 45);
      step();
      chk("rep_key_out", key_out, {3'b111, blip});
      chk("rep_press", press_pulse, {3'b000, pulse});
    end

    // 3: hold without repeat, then release
    do_reset();
    repeat_en = 1'b0;
    press_key0("t3");
    for (int c = 1; c < 50; c++) begin
      step();
      chk("norep_key_out", key_out, 4'hE);
      chk("norep_press", press_pulse, 4'h0);
    end
    key_raw[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rel_wait", key_out, 4'hE);
    end
    step();
    chk("rel_rise", key_out, 4'hF);
    chk("rel_press", press_pulse, 4'h0);

    // 4: reset mid-hold with the key still down
    do_reset();
    repeat_en = 1'b1;
    press_key0("t4a");
    repeat (10) step();
    chk("hold10_key_out", key_out, 4'hE);
    reset_n = 1'b0;
    step();
    chk("midrst_key_out", key_out, 4'hF);
    chk("midrst_press", press_pulse, 4'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rerst_wait", key_out, 4'hF);
    end
    step();
    chk("rerst_fall", key_out, 4'hE);
    chk("rerst_press", press_pulse, 4'h1);
    step();
    chk("rerst_press_once", press_pulse, 4'h0);

    // 5: keys 0 and 3 pressed together
    do_reset();
    key_raw = 4'b0110;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("dual_wait", key_out, 4'hF);
    end
    step();
    chk("dual_fall", key_out, 4'b0110);
    chk("dual_press", press_pulse, 4'b1001);
    step();
    chk("dual_press_once", press_pulse, 4'h0);

    // 6: release completes on the blip cycle
    do_reset();
    press_key0("t6");
    repeat (14) step();
    key_raw[0] = 1'b1;
    for (int c = 15; c <= 19; c++) begin
      step();
      chk("race_hold", key_out, 4'hE);
    end
    step();
    chk("race_c20_key_out", key_out, 4'hF);
    chk("race_c20_press", press_pulse, 4'h0);
    for (int c = 21; c <= 40; c++) begin
      step();
      chk("race_after_key_out", key_out, 4'hF);
      chk("race_after_press", press_pulse, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
